// File: rtl/store_buf_pkg.sv
// Shared types and helpers for the posted-store write buffer.
// Optional load forwarding is enabled by defining STORE_BUF_FWD_EN.
package store_buf_pkg;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } sb_state_t;

    // Pointer width for a queue of 'depth' entries; at least one bit.
    function automatic int sb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/store_buf_fwd_match.sv
// Load-forwarding lookup for the store write buffer (used when STORE_BUF_FWD_EN is defined).
// Entries are scanned by age relative to the write pointer; the youngest match wins.
module store_buf_fwd_match #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int CNT_W  = 3
) (
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [ADDR_W-1:0] i_entry_addr [DEPTH],
    input  logic [DATA_W-1:0] i_entry_data [DEPTH],
    input  logic [PTR_W-1:0]  i_wr_ptr,
    input  logic [CNT_W-1:0]  i_count,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    // Bit gi corresponds to the (gi+1)-th youngest entry.
    logic [DEPTH-1:0]  w_match;
    logic [DATA_W-1:0] w_age_data [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] w_idx;
            assign w_idx          = i_wr_ptr - PTR_W'(gi + 1);
            assign w_match[gi]    = (CNT_W'(gi + 1) <= i_count) && (i_entry_addr[w_idx] == i_ld_addr);
            assign w_age_data[gi] = i_entry_data[w_idx];
        end
    endgenerate

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                o_hit  = 1'b1;
                o_data = w_age_data[k];
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// In-order posted-store queue draining to a req/ack data memory.
// Define STORE_BUF_FWD_EN to forward queued store data to matching loads.
module store_write_buffer
    import store_buf_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        st_valid_i,
    input  logic [ADDR_W-1:0]           st_addr_i,
    input  logic [DATA_W-1:0]           st_data_i,
    output logic                        st_ready_o,
    input  logic [ADDR_W-1:0]           ld_addr_i,
    output logic                        ld_hit_o,
    output logic [DATA_W-1:0]           ld_data_o,
    output logic                        mem_req_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_data_o,
    input  logic                        mem_ack_i,
    output logic                        empty_o,
    output logic [sb_ptr_w(DEPTH):0]    count_o
);

    localparam int PTR_W = sb_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           r_mem [DEPTH];
    entry_t           r_head;
    entry_t           w_head_next;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_inc;
    logic [CNT_W-1:0] r_count;
    sb_state_t        r_state;
    sb_state_t        w_state_next;
    logic             w_push;
    logic             w_pop;
    logic             w_load_head;

    // Readiness uses only the registered count: a pop never frees a slot same-cycle.
    assign st_ready_o   = (r_count != FULL_CNT);
    assign w_push       = st_valid_i & st_ready_o;
    assign w_pop        = (r_state == SB_REQ) & mem_ack_i;
    assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{addr: st_addr_i, data: st_data_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= SB_IDLE;
            r_head   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_state <= w_state_next;
            if (w_load_head) r_head <= w_head_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_head  = 1'b0;
        w_head_next  = r_mem[r_rd_ptr];
        case (r_state)
            SB_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = SB_REQ;
                    w_load_head  = 1'b1;
                end
            end
            SB_REQ: begin
                if (mem_ack_i) begin
                    if (r_count != ONE_CNT) begin
                        w_load_head = 1'b1;
                        w_head_next = r_mem[w_rd_ptr_inc];
                    end else if (w_push) begin
                        // Queue drains to this very store; it is not in the array yet.
                        w_load_head = 1'b1;
                        w_head_next = '{addr: st_addr_i, data: st_data_i};
                    end else begin
                        w_state_next = SB_IDLE;
                    end
                end
            end
            default: w_state_next = SB_IDLE;
        endcase
    end

    assign mem_req_o  = (r_state == SB_REQ);
    assign mem_addr_o = r_head.addr;
    assign mem_data_o = r_head.data;
    assign count_o    = r_count;
    assign empty_o    = (r_count == '0) && (r_state == SB_IDLE);

`ifdef STORE_BUF_FWD_EN
    logic [ADDR_W-1:0] w_ent_addr [DEPTH];
    logic [DATA_W-1:0] w_ent_data [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign w_ent_addr[gi] = r_mem[gi].addr;
            assign w_ent_data[gi] = r_mem[gi].data;
        end
    endgenerate

    store_buf_fwd_match #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_fwd (
        .i_ld_addr    (ld_addr_i),
        .i_entry_addr (w_ent_addr),
        .i_entry_data (w_ent_data),
        .i_wr_ptr     (r_wr_ptr),
        .i_count      (r_count),
        .o_hit        (ld_hit_o),
        .o_data       (ld_data_o)
    );
`else
    logic w_unused_ld;
    assign w_unused_ld = ^ld_addr_i;
    assign ld_hit_o    = 1'b0;
    assign ld_data_o   = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer (DEPTH=4).
// Forwarding checks follow STORE_BUF_FWD_EN when the bench is built with it.
module tb_store_write_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        st_valid_i = 1'b0;
    logic [31:0] st_addr_i = '0;
    logic [31:0] st_data_i = '0;
    logic        st_ready_o;
    logic [31:0] ld_addr_i = '0;
    logic        ld_hit_o;
    logic [31:0] ld_data_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_ack_i = 1'b0;
    logic        empty_o;
    logic [2:0]  count_o;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] a_tab [5];
    logic [31:0] d_tab [5];

    store_write_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .st_valid_i (st_valid_i),
        .st_addr_i  (st_addr_i),
        .st_data_i  (st_data_i),
        .st_ready_o (st_ready_o),
        .ld_addr_i  (ld_addr_i),
        .ld_hit_o   (ld_hit_o),
        .ld_data_o  (ld_data_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_ack_i  (mem_ack_i),
        .empty_o    (empty_o),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        st_valid_i = 1'b1;
        st_addr_i  = a;
        st_data_i  = d;
        $display("store addr=0x%08h data=0x%08h ready=%0b count=%0d", a, d, st_ready_o, count_o);
        tick();
        st_valid_i = 1'b0;
    endtask

    initial begin
        // 1: reset then idle
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (5) tick();
        check("t1_req", mem_req_o, 0);
        check("t1_empty", empty_o, 1);
        check("t1_ready", st_ready_o, 1);
        check("t1_count", count_o, 0);
        check("t1_hit", ld_hit_o, 0);

        // 2: single store, ack three cycles after req
        push(32'h100, 32'hAAAA_0001);
        check("t2_count_N", count_o, 1);
        check("t2_req_N", mem_req_o, 0);
        tick();
        check("t2_req_N1", mem_req_o, 1);
        check("t2_addr", mem_addr_o, 32'h100);
        check("t2_data", mem_data_o, 32'hAAAA_0001);
        repeat (2) begin
            tick();
            check("t2_req_hold", mem_req_o, 1);
            check("t2_addr_hold", mem_addr_o, 32'h100);
            check("t2_data_hold", mem_data_o, 32'hAAAA_0001);
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        $display("ack write addr=0x100");
        check("t2_count_ack", count_o, 0);
        check("t2_req_ack", mem_req_o, 0);
        check("t2_empty_ack", empty_o, 1);

        // 3: five pushes without ack, then back-to-back drain
        for (int i = 0; i < 5; i++) begin
            a_tab[i] = 32'h1000 + 32'(i * 4);
            d_tab[i] = 32'h3000_0000 + 32'(i);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("t3_ready_full", st_ready_o, 0);
            push(a_tab[i], d_tab[i]);
        end
        check("t3_count_full", count_o, 4);
        check("t3_ready", st_ready_o, 0);
        check("t3_req", mem_req_o, 1);
        mem_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_req_b2b", mem_req_o, 1);
            check("t3_addr", mem_addr_o, a_tab[i]);
            check("t3_data", mem_data_o, d_tab[i]);
            $display("ack write addr=0x%08h data=0x%08h", mem_addr_o, mem_data_o);
            tick();
            check("t3_count", count_o, 64'(3 - i));
        end
        mem_ack_i = 1'b0;
        check("t3_req_done", mem_req_o, 0);
        tick();
        check("t3_dropped", count_o, 0);
        check("t3_empty", empty_o, 1);

        // 4: full queue, push and ack in the same cycle
        for (int i = 0; i < 4; i++) begin
            a_tab[i] = 32'h2000 + 32'(i * 4);
            d_tab[i] = 32'h4000_0000 + 32'(i);
            push(a_tab[i], d_tab[i]);
        end
        st_valid_i = 1'b1;
        st_addr_i  = 32'hDEAD_0000;
        st_data_i  = 32'h0000_0BAD;
        mem_ack_i  = 1'b1;
        check("t4_ready_full", st_ready_o, 0);
        tick();
        st_valid_i = 1'b0;
        check("t4_count", count_o, 3);
        check("t4_ready", st_ready_o, 1);
        for (int i = 1; i < 4; i++) begin
            check("t4_addr", mem_addr_o, a_tab[i]);
            check("t4_data", mem_data_o, d_tab[i]);
            $display("ack write addr=0x%08h data=0x%08h", mem_addr_o, mem_data_o);
            tick();
        end
        mem_ack_i = 1'b0;
        check("t4_count_done", count_o, 0);
        check("t4_req_done", mem_req_o, 0);

        // 4b: last entry acked while a new store pushes
        push(32'h300, 32'h5555_0001);
        tick();
        check("t4b_addr0", mem_addr_o, 32'h300);
        mem_ack_i = 1'b1;
        push(32'h304, 32'h5555_0002);
        check("t4b_count", count_o, 1);
        check("t4b_req", mem_req_o, 1);
        check("t4b_addr1", mem_addr_o, 32'h304);
        check("t4b_data1", mem_data_o, 32'h5555_0002);
        tick();
        mem_ack_i = 1'b0;
        check("t4b_empty", empty_o, 1);

        // 5: load forwarding
        push(32'h200, 32'h11);
        push(32'h200, 32'h22);
        ld_addr_i = 32'h200;
        #1;
`ifdef STORE_BUF_FWD_EN
        check("t5_hit", ld_hit_o, 1);
        check("t5_data", ld_data_o, 32'h22);
`else
        check("t5_hit_off", ld_hit_o, 0);
        check("t5_data_off", ld_data_o, 0);
`endif
        ld_addr_i = 32'h204;
        #1;
        check("t5_miss", ld_hit_o, 0);
        $display("load addr=0x204 hit=%0b", ld_hit_o);
        mem_ack_i = 1'b1;
        tick();
        tick();
        mem_ack_i = 1'b0;
        check("t5_count", count_o, 0);

        // 6: asynchronous reset while a write is pending
        push(32'h600, 32'h6000_0000);
        push(32'h604, 32'h6000_0001);
        push(32'h608, 32'h6000_0002);
        check("t6_req_pre", mem_req_o, 1);
        check("t6_count_pre", count_o, 3);
        rst_i = 1'b1;
        #1;
        check("t6_req_async", mem_req_o, 0);
        check("t6_count", count_o, 0);
        check("t6_empty", empty_o, 1);
        check("t6_ready", st_ready_o, 1);
        check("t6_addr", mem_addr_o, 0);
        check("t6_data", mem_data_o, 0);
        check("t6_hit", ld_hit_o, 0);
        tick();
        rst_i     = 1'b0;
        mem_ack_i = 1'b1;
        tick();
        tick();
        mem_ack_i = 1'b0;
        check("t6_req_post", mem_req_o, 0);
        check("t6_count_post", count_o, 0);
        check("t6_empty_post", empty_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
